sum_arbiter: RTL and testbench
==============================

SUM_ARBITER -- requirements
Module: sum_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles spent in WAIT before abort (1..255).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request, level; requester i holds req[i] until ack[i].
REQ-006 opnd  input  16*WIDTH  operand sets; requester i, operand k at bits [(4*i+k)*WIDTH +: WIDTH].
REQ-007 gnt  output  4  one-hot grant, high from grant through RESP of requester's operation.
REQ-008 ack  output  4  one-hot, one-cycle pulse; result/err valid in that cycle.
REQ-009 result  output  WIDTH  latched sum of granted requester.
REQ-010 err  output  1  high with ack when the operation timed out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ms_in0..ms_in3  output  WIDTH each  operands to the shared accumulator.
REQ-013 ms_start  output  1  accumulator start, one-cycle pulse.
REQ-014 ms_done  input  1  accumulator completion pulse; ms_sum valid in that cycle.
REQ-015 ms_sum  input  WIDTH  accumulator result.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; RESP always returns to IDLE (no direct RESP->ISSUE).
REQ-017 IDLE: if any req bit set, select winner, go to ISSUE; else stay.
REQ-018 Winner: round-robin; search starts at pointer p, ascending with wrap 3->0; first set req bit wins.
REQ-019 On grant to i: p <= (i+1) mod 4; gnt <= one-hot i; opnd set i latched into ms_in0..3.
REQ-020 ms_in0..3 SHALL stay constant from ISSUE until return to IDLE; later opnd changes ignored.
REQ-021 ISSUE: ms_start=1 for exactly that one cycle; next state WAIT; wait counter cleared.
REQ-022 WAIT: on ms_done=1, latch result<=ms_sum, err<=0, go to RESP.
REQ-023 WAIT: counter increments each cycle without ms_done; at TIMEOUT cycles go to RESP with result<=0, err<=1.
REQ-024 ms_done arriving in the same cycle as the timeout threshold: done wins, err=0.
REQ-025 RESP: ack[i]=1 for one cycle with gnt[i]; then gnt<=0, go to IDLE.
REQ-026 ms_done outside WAIT SHALL be ignored without state change.
REQ-027 req[i] dropped mid-operation: operation completes, ack[i] still pulsed.
REQ-028 Accumulator contract: ms_done pulses 6 cycles after the cycle ms_start is sampled; sum is modulo 2^WIDTH.
REQ-029 Nominal latency: req seen in IDLE cycle 0 -> ms_start cycle 1 -> ms_done cycle 7 -> ack cycle 8; next grant earliest cycle 10.
REQ-030 Never more than one gnt bit or one ack bit high in any cycle.

Reset
REQ-031 reset in any state: state<=IDLE, p<=0, gnt=0, ack=0, err=0, result=0, ms_in0..3=0, ms_start=0, busy=0, counter=0.
REQ-032 reset mid-operation discards the operation; no ack issued for it.
REQ-033 First cycle after reset deassertion behaves as IDLE with p=0.

Verification (bench includes a behavioural accumulator honoring REQ-028)
REQ-034 req=0010, opnd set1 = 1,2,3,4 -> gnt=0010 cycles 1..8, ms_start cycle 1, ack=0010 cycle 8, result=10, err=0.
REQ-035 req=1111 held, acks drop each bit -> grant order 0,1,2,3; re-raise req[0] -> granted again; acks 9 cycles apart.
REQ-036 set0 = 0xFFFFFFFF,1,0,0 -> result=0x00000000, err=0 (wrap).
REQ-037 accumulator never asserts ms_done -> ack pulse 15 WAIT cycles after ms_start, err=1, result=0, then IDLE.
REQ-038 reset pulsed during WAIT -> all outputs at REQ-031 values next cycle, no ack; new req=0100 grants requester 2 normally.
REQ-039 opnd changed and req dropped during WAIT -> ms_in unchanged, ack still issued with original sum.

Source files
------------

// File: rtl/sum_arbiter.sv
// sum_arbiter: four-requester round-robin front end for a shared four-operand
// accumulator. One operation is in flight at a time: the winner's operand set
// is latched and issued, the accumulator result (or a timeout) is captured,
// and the requester receives a one-cycle ack carrying result/err.
module sum_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [16*WIDTH-1:0]   opnd,
    output logic [3:0]            gnt,
    output logic [3:0]            ack,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      ms_in0,
    output logic [WIDTH-1:0]      ms_in1,
    output logic [WIDTH-1:0]      ms_in2,
    output logic [WIDTH-1:0]      ms_in3,
    output logic                  ms_start,
    input  logic                  ms_done,
    input  logic [WIDTH-1:0]      ms_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last WAIT cycle index: WAIT is left by timeout after TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_r;
    logic [1:0]       ptr_r;
    logic [7:0]       cnt_r;

    logic             win_found_s;
    logic [1:0]       win_idx_s;
    logic [1:0]       cand_s;
    logic [WIDTH-1:0] opnd_set_s [4][4];

    // Unpack the flat operand bus into [requester][operand] words.
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
        for (genvar gk = 0; gk < 4; gk++) begin : g_opnd
            assign opnd_set_s[gi][gk] = opnd[(4*gi+gk)*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: scan from ptr upward with wrap; the nearest set bit wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_s = ptr_r + 2'(k);
            if (req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            ptr_r    <= 2'd0;
            cnt_r    <= 8'd0;
            gnt      <= 4'd0;
            ack      <= 4'd0;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            ms_in0   <= '0;
            ms_in1   <= '0;
            ms_in2   <= '0;
            ms_in3   <= '0;
            ms_start <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        ptr_r    <= win_idx_s + 2'd1;
                        gnt      <= 4'b0001 << win_idx_s;
                        ms_in0   <= opnd_set_s[win_idx_s][0];
                        ms_in1   <= opnd_set_s[win_idx_s][1];
                        ms_in2   <= opnd_set_s[win_idx_s][2];
                        ms_in3   <= opnd_set_s[win_idx_s][3];
                        ms_start <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                ISSUE: begin
                    ms_start <= 1'b0;
                    cnt_r    <= 8'd0;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    // A completion in the threshold cycle still counts as success.
                    if (ms_done) begin
                        result  <= ms_sum;
                        err     <= 1'b0;
                        ack     <= gnt;
                        state_r <= RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        result  <= '0;
                        err     <= 1'b1;
                        ack     <= gnt;
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    ack     <= 4'd0;
                    gnt     <= 4'd0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    cnt_r   <= 8'd0;
                    state_r <= IDLE;
                end
                default: begin
                    ack      <= 4'd0;
                    gnt      <= 4'd0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    ms_start <= 1'b0;
                    cnt_r    <= 8'd0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: a behavioural accumulator with programmable latency,
// a transaction-level reference model feeding a scoreboard queue, and a
// monitor that checks grant/busy/start windows, operand stability and acks.
module tb_sum_arbiter;

    localparam int W  = 32;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      req = 4'd0;
    logic [16*W-1:0] opnd = '0;
    logic [3:0]      gnt, ack;
    logic [W-1:0]    result;
    logic            err, busy, ms_start;
    logic [W-1:0]    ms_in0, ms_in1, ms_in2, ms_in3;
    logic            ms_done = 1'b0;
    logic [W-1:0]    ms_sum = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_lat = 6;   // accumulator latency; 0 means it never answers

    typedef struct {
        int             idx;
        int             g;
        int             ack_c;
        logic [W-1:0]   res;
        logic           err;
        logic [4*W-1:0] ops;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int           t;
        logic [W-1:0] s;
    } pend_t;
    pend_t pend[$];

    sum_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .opnd(opnd),
        .gnt(gnt), .ack(ack), .result(result), .err(err), .busy(busy),
        .ms_in0(ms_in0), .ms_in1(ms_in1), .ms_in2(ms_in2), .ms_in3(ms_in3),
        .ms_start(ms_start), .ms_done(ms_done), .ms_sum(ms_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural accumulator: sample ms_start, answer acc_lat cycles later.
    initial forever begin
        @(negedge clk);
        if (reset) pend.delete();
        else if (ms_start && acc_lat != 0) begin
            pend_t p;
            p.t = cyc + acc_lat;
            p.s = ms_in0 + ms_in1 + ms_in2 + ms_in3;
            pend.push_back(p);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        ms_done = 1'b0;
        ms_sum  = '0;
        while (pend.size() > 0 && pend[0].t < cyc) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].t == cyc) begin
            ms_done = 1'b1;
            ms_sum  = pend[0].s;
            void'(pend.pop_front());
        end
    end

    // Reference model: arbitration decisions and expected responses per transaction.
    int next_free = 0;
    int m_ptr = 0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            next_free = cyc + 1;
            m_ptr = 0;
        end else if (cyc >= next_free && req != 4'd0) begin
            exp_t e;
            logic [W-1:0] s;
            e.idx = -1;
            for (int k = 0; k < 4; k++)
                if (e.idx < 0 && req[(m_ptr + k) % 4]) e.idx = (m_ptr + k) % 4;
            s = '0;
            for (int k = 0; k < 4; k++) begin
                e.ops[k*W +: W] = opnd[(4*e.idx+k)*W +: W];
                s = s + opnd[(4*e.idx+k)*W +: W];
            end
            e.g = cyc;
            if (acc_lat >= 1 && acc_lat <= TO) begin
                e.ack_c = cyc + acc_lat + 2;
                e.res = s;
                e.err = 1'b0;
            end else begin
                e.ack_c = cyc + TO + 2;
                e.res = '0;
                e.err = 1'b1;
            end
            exp_q.push_back(e);
            next_free = e.ack_c + 1;
            m_ptr = (e.idx + 1) % 4;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard head every cycle.
    initial forever begin
        logic [3:0] eg;
        bit have;
        @(negedge clk);
        if (!reset) begin
            have = exp_q.size() > 0;
            chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
            chk("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
            eg = 4'd0;
            if (have && cyc >= exp_q[0].g + 1 && cyc <= exp_q[0].ack_c)
                eg = 4'b0001 << exp_q[0].idx;
            chk("gnt", 64'(gnt), 64'(eg));
            chk("busy", 64'(busy), 64'(eg != 4'd0));
            chk("ms_start", 64'(ms_start), 64'(have && cyc == exp_q[0].g + 1));
            if (eg != 4'd0) begin
                chk("ms_in0", 64'(ms_in0), 64'(exp_q[0].ops[0*W +: W]));
                chk("ms_in1", 64'(ms_in1), 64'(exp_q[0].ops[1*W +: W]));
                chk("ms_in2", 64'(ms_in2), 64'(exp_q[0].ops[2*W +: W]));
                chk("ms_in3", 64'(ms_in3), 64'(exp_q[0].ops[3*W +: W]));
            end
            if (ack != 4'd0 || (have && cyc >= exp_q[0].ack_c)) begin
                if (!have) begin
                    chk("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack", 64'(ack), 64'(4'b0001 << e.idx));
                    chk("ack_cycle", 64'(cyc), 64'(e.ack_c));
                    chk("result", 64'(result), 64'(e.res));
                    chk("err", 64'(err), 64'(e.err));
                end
            end
        end
    end

    task automatic run_cycles(input int n, input int raise_pct, input int drop_pct, input bit rnd_op);
        logic [3:0] sack;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            sack = ack;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && sack[i]) req[i] = 1'b0;
                else if (req[i] && int'($urandom_range(99)) < drop_pct) req[i] = 1'b0;
                else if (!req[i] && int'($urandom_range(99)) < raise_pct) req[i] = 1'b1;
            end
            if (rnd_op)
                for (int k = 0; k < 16; k++) opnd[k*W +: W] = $urandom;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            run_cycles(1, 0, 0, 1'b0);
            if (req == 4'd0 && exp_q.size() == 0) done = 1'b1;
        end
        chk("drain_bound", 64'(done), 64'd1);
    endtask

    task automatic check_reset_values();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ms_start", 64'(ms_start), 64'd0);
        chk("rst_ms_in", 64'({ms_in0, ms_in1} | {ms_in2, ms_in3}), 64'd0);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, b, c, d);
        opnd[(4*i+0)*W +: W] = a;
        opnd[(4*i+1)*W +: W] = b;
        opnd[(4*i+2)*W +: W] = c;
        opnd[(4*i+3)*W +: W] = d;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;

        // All four requesting from p=0, then requester 0 again.
        for (int k = 0; k < 16; k++) opnd[k*W +: W] = $urandom;
        req = 4'b1111;
        wait_idle();
        req = 4'b0001;
        wait_idle();

        // Requester 1 with operands 1,2,3,4.
        set_ops(1, 32'd1, 32'd2, 32'd3, 32'd4);
        req = 4'b0010;
        wait_idle();

        // Modular wrap of the sum.
        set_ops(0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        req = 4'b0001;
        wait_idle();

        // Operands changed and request dropped while the operation is in flight.
        set_ops(3, 32'd100, 32'd200, 32'd300, 32'd400);
        req = 4'b1000;
        run_cycles(4, 0, 0, 1'b0);
        req = 4'b0000;
        for (int k = 0; k < 16; k++) opnd[k*W +: W] = $urandom;
        wait_idle();

        // Accumulator silent, done in the threshold cycle, done one cycle too late.
        acc_lat = 0;  req = 4'b0100; wait_idle();
        acc_lat = TO; req = 4'b0010; wait_idle();
        acc_lat = TO + 1; req = 4'b0001; wait_idle();
        acc_lat = 6;

        // Reset while waiting on the accumulator; the operation must vanish.
        req = 4'b0001;
        run_cycles(6, 0, 0, 1'b0);
        reset = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        set_ops(2, 32'd7, 32'd8, 32'd9, 32'd10);
        req = 4'b0100;
        wait_idle();

        // Randomised traffic across several accumulator latencies.
        for (int r = 0; r < 7; r++) begin
            case (r)
                0: acc_lat = 6;
                1: acc_lat = 1;
                2: acc_lat = 3;
                3: acc_lat = TO;
                4: acc_lat = TO + 1;
                5: acc_lat = 0;
                default: acc_lat = int'($urandom_range(12)) + 1;
            endcase
            run_cycles(250, 25, 3, 1'b1);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
